// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    // Default operand widths: 16-bit dividend/quotient, 8-bit divisor/remainder
    localparam int unsigned NW_DEF = 16;
    localparam int unsigned DW_DEF = 8;

    // Counter width able to hold 0..nw
    function automatic int unsigned cnt_w(input int unsigned nw);
        return $clog2(nw + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_w(NW_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW:0]   rem,
    input  logic          nbit,
    input  logic [DW-1:0] d,
    output logic [DW:0]   rem_next,
    output logic          qbit
);

    logic [DW:0]   sh;
    logic [DW+1:0] diff;
    // The incoming remainder is always < d, so its MSB is zero
    logic          unused_rem_msb;

    assign unused_rem_msb = rem[DW];

    // Shift, trial subtract with a sign bit, then select kept or restored remainder
    always_comb begin
        sh       = {rem[DW-1:0], nbit};
        diff     = {1'b0, sh} - {2'b00, d};
        qbit     = ~diff[DW+1];
        rem_next = qbit ? diff[DW:0] : sh;
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential radix-2 restoring divider, NW-bit dividend by DW-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
// Optional macro APPROX_DIV_TRUNC_EN: skip the low TRUNC_BITS quotient bits.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int unsigned NW         = NW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned TRUNC_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          div_zero
);

`ifdef APPROX_DIV_TRUNC_EN
    localparam int unsigned SKIP = TRUNC_BITS;
`else
    // Exact divide: no quotient bits are skipped
    localparam int unsigned SKIP = 0 * TRUNC_BITS;
`endif

    localparam int unsigned ITER = NW - SKIP;
    localparam int unsigned CW   = cnt_w(NW);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_e        state_q;
    logic [NW-1:0] dvd_q;
    logic [DW-1:0] dsr_q;
    logic [DW:0]   rem_q;
    logic [NW-1:0] quo_q;
    logic [CW-1:0] cnt_q;

    logic [DW:0]   step_rem;
    logic          step_q;
    logic [NW-1:0] quo_next;

    div_step #(
        .DW (DW)
    ) u_step (
        .rem      (rem_q),
        .nbit     (dvd_q[NW-1]),
        .d        (dsr_q),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    assign quo_next = {quo_q[NW-2:0], step_q};

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        dvd_q    <= N;
                        dsr_q    <= D;
                        rem_q    <= '0;
                        quo_q    <= '0;
                        cnt_q    <= '0;
                        div_zero <= (D == '0);
                        in_ready <= 1'b0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (div_zero) begin
                        // Zero divisor spends exactly one cycle here, no iterations
                        Q         <= '1;
                        R         <= dvd_q[DW-1:0];
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= quo_next;
                        dvd_q <= dvd_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            // Skipped low quotient bits read back as zero
                            Q         <= quo_next << SKIP;
                            R         <= step_rem[DW-1:0];
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq against an arithmetic reference model.
module tb_div_16x8_seq;

`ifdef APPROX_DIV_TRUNC_EN
    localparam int SKIP = 4;
`else
    localparam int SKIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] N = '0;
    logic [7:0]  D = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        div_zero;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    div_16x8_seq #(
        .NW         (16),
        .DW         (8),
        .TRUNC_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .div_zero  (div_zero)
    );

    // Reference: plain integer division, optionally on the truncated dividend
    function automatic void model(input logic [15:0] n, input logic [7:0] d,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
        int unsigned nn;
        nn = int'(n) >> SKIP;
        if (d == 0) begin
            q = 16'hFFFF; r = n[7:0]; z = 1'b1; lat = 1;
        end else begin
            q = 16'((nn / int'(d)) << SKIP);
            r = 8'(nn % int'(d));
            z = 1'b0;
            lat = 16 - SKIP;
        end
    endfunction

    // Drive one operation with out_ready=1 and collect its result and latency
    task automatic do_op(input logic [15:0] n, input logic [7:0] d,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic z, output int lat);
        int guard;
        @(negedge clk);
        N = n; D = d; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        q = Q; r = R; z = div_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (Q !== 16'h0) begin nerr++; $display("FAIL reset_Q got %h want 0", Q); end
        nvec++; if (R !== 8'h0) begin nerr++; $display("FAIL reset_R got %h want 0", R); end
        nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] tn [5] = '{16'd1000, 16'd65535, 16'd255, 16'd5, 16'h1234};
        logic [7:0]  td [5] = '{8'd7, 8'd1, 8'd255, 8'd200, 8'd0};
        logic [15:0] q, eq;
        logic [7:0]  r, er;
        logic        z, ez;
        int          lat, elat;
        for (int i = 0; i < 5; i++) begin
            model(tn[i], td[i], eq, er, ez, elat);
            do_op(tn[i], td[i], q, r, z, lat);
            nvec++; if (q !== eq) begin nerr++; $display("FAIL dir_Q %0d/%0d got %0d want %0d", tn[i], td[i], q, eq); end
            nvec++; if (r !== er) begin nerr++; $display("FAIL dir_R %0d/%0d got %0d want %0d", tn[i], td[i], r, er); end
            nvec++; if (z !== ez) begin nerr++; $display("FAIL dir_zero %0d/%0d got %b want %b", tn[i], td[i], z, ez); end
            nvec++; if (lat !== elat) begin nerr++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", tn[i], td[i], lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] eq, eq2, hq;
        logic [7:0]  er, er2, hr;
        logic        ez;
        int          elat, lat;
        model(16'd300, 8'd7, eq, er, ez, elat);
        model(16'd999, 8'd3, eq2, er2, ez, elat);
        @(negedge clk);
        N = 16'd300; D = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Present a second operand pair while busy; it must wait
        N = 16'd999; D = 8'd3;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_busy_in_ready got %b want 0", in_ready); end
        end
        nvec++; if (Q !== eq || R !== er) begin
            nerr++; $display("FAIL bp_result got %0d r%0d want %0d r%0d", Q, R, eq, er);
        end
        hq = Q; hr = R;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== hq || R !== hr) begin
                nerr++; $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b Q=%0d R=%0d want 1/0/%0d/%0d",
                                 i, out_valid, in_ready, Q, R, hq, hr);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_second_accept got rdy=%b want 0", in_ready); end
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        nvec++; if (Q !== eq2 || R !== er2 || lat !== elat) begin
            nerr++; $display("FAIL bp_second got %0d r%0d lat %0d want %0d r%0d lat %0d", Q, R, lat, eq2, er2, elat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, eq;
        logic [7:0]  r, er;
        logic        z, ez;
        int          lat, elat;
        @(negedge clk);
        N = 16'd1000; D = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== 16'h0 || R !== 8'h0 || div_zero !== 1'b0) begin
            nerr++; $display("FAIL midrst_values got rdy=%b vld=%b Q=%h R=%h z=%b want 1/0/0/0/0",
                             in_ready, out_valid, Q, R, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_no_pulse cyc %0d got 1 want 0", i); end
        end
        model(16'd100, 8'd9, eq, er, ez, elat);
        do_op(16'd100, 8'd9, q, r, z, lat);
        nvec++; if (q !== eq || r !== er || z !== ez || lat !== elat) begin
            nerr++; $display("FAIL midrst_after got %0d r%0d z%b lat %0d want %0d r%0d z%b lat %0d",
                             q, r, z, lat, eq, er, ez, elat);
        end
    endtask

    task automatic test_random();
        logic [15:0] n, q, eq;
        logic [7:0]  d, r, er;
        logic        z, ez;
        int          lat, elat;
        for (int i = 0; i < 2000; i++) begin
            n = 16'($urandom);
            d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            model(n, d, eq, er, ez, elat);
            do_op(n, d, q, r, z, lat);
            nvec++; if (q !== eq || r !== er || z !== ez || lat !== elat) begin
                nerr++; $display("FAIL rand %0d/%0d got %0d r%0d z%b lat %0d want %0d r%0d z%b lat %0d",
                                 n, d, q, r, z, lat, eq, er, ez, elat);
            end
`ifndef APPROX_DIV_TRUNC_EN
            if (d != 0) begin
                nvec++; if ((int'(q) * int'(d) + int'(r)) != int'(n) || r >= d) begin
                    nerr++; $display("FAIL rand_identity %0d/%0d got q=%0d r=%0d want n=q*d+r, r<d", n, d, q, r);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
